mor1kx_cfgrs_spr: RTL and testbench

SPR-bus-accessible configuration and control register block for group 0 of the mor1kx SPR space. It generates the read-only identification and configuration registers (VR, VR2, AVR, UPR, CPUCFGR, MMU, cache, debug and perf-counter config) from synthesis parameters. It also holds the writable group-0 state: EVBAR, AECR and AESR, plus the multicore COREID/NUMCORES pair. It sits between the pipeline's SPR bus master and the exception logic, replacing direct wiring of constant config vectors.

---
 rtl/mor1kx_cfgrs_spr_pkg.sv | 57 +++++
 rtl/mor1kx_cfgrs_words.sv | 99 +++++++++
 rtl/mor1kx_cfgrs_spr.sv | 224 ++++++++++++++++++++++
 tb/tb_mor1kx_cfgrs_spr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_cfgrs_spr_pkg.sv
// Shared definitions for the mor1kx group-0 configuration/control SPR block.
// Holds the group-0 SPR index map, the AECR/AESR cause bit positions, the OR1K
// architecture field positions used to assemble the config words, the bus FSM
// state type and a helper that encodes cache way counts.
package mor1kx_cfgrs_spr_pkg;

    // Group-0 SPR indices (addr[10:0])
    localparam logic [10:0] OR1K_SPR_VR_IDX       = 11'd0;
    localparam logic [10:0] OR1K_SPR_UPR_IDX      = 11'd1;
    localparam logic [10:0] OR1K_SPR_CPUCFGR_IDX  = 11'd2;
    localparam logic [10:0] OR1K_SPR_DMMUCFGR_IDX = 11'd3;
    localparam logic [10:0] OR1K_SPR_IMMUCFGR_IDX = 11'd4;
    localparam logic [10:0] OR1K_SPR_DCCFGR_IDX   = 11'd5;
    localparam logic [10:0] OR1K_SPR_ICCFGR_IDX   = 11'd6;
    localparam logic [10:0] OR1K_SPR_DCFGR_IDX    = 11'd7;
    localparam logic [10:0] OR1K_SPR_PCCFGR_IDX   = 11'd8;
    localparam logic [10:0] OR1K_SPR_VR2_IDX      = 11'd9;
    localparam logic [10:0] OR1K_SPR_AVR_IDX      = 11'd10;
    localparam logic [10:0] OR1K_SPR_EVBAR_IDX    = 11'd11;
    localparam logic [10:0] OR1K_SPR_AECR_IDX     = 11'd12;
    localparam logic [10:0] OR1K_SPR_AESR_IDX     = 11'd13;
    localparam logic [10:0] OR1K_SPR_COREID_IDX   = 11'd128;
    localparam logic [10:0] OR1K_SPR_NUMCORES_IDX = 11'd129;

    // AECR/AESR cause bits
    localparam int unsigned OR1K_AE_CYADDE    = 0;
    localparam int unsigned OR1K_AE_OVADDE    = 1;
    localparam int unsigned OR1K_AE_CYMULE    = 2;
    localparam int unsigned OR1K_AE_OVMULE    = 3;
    localparam int unsigned OR1K_AE_DBZE      = 4;
    localparam int unsigned OR1K_AE_CYMACADDE = 5;
    localparam int unsigned OR1K_AE_OVMACADDE = 6;
    localparam int unsigned OR1K_AE_WIDTH     = 7;

    // EVBAR implements only the vector base above the 8 KiB table
    localparam int unsigned OR1K_EVBAR_LSB = 13;

    // Architecture version constants
    localparam logic [7:0] OR1K_VR_VERSION  = 8'h12;
    localparam logic [7:0] OR1K_VR2_CPUID   = 8'h01;
    localparam logic [7:0] OR1K_VR2_VERSION = 8'h05;
    localparam logic [7:0] OR1K_AVR_MAJOR   = 8'h01;
    localparam logic [7:0] OR1K_AVR_MINOR   = 8'h01;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } spr_state_t;

    // NCW = log2(ways) with the way count clamped to the encodable 1..32
    function automatic logic [2:0] cache_ncw(input int unsigned ways);
        int unsigned w;
        w = (ways < 1) ? 1 : ((ways > 32) ? 32 : ways);
        return 3'($clog2(w));
    endfunction

endpackage

// File: rtl/mor1kx_cfgrs_words.sv
// Parameter-to-vector generation of the read-only group-0 configuration words.
// Purely combinational; every output is a constant for a given parameter set.
// Outputs: vr, vr2, avr, upr, cpucfgr, dmmucfgr, immucfgr, dccfgr, iccfgr,
// dcfgr, pccfgr (all 32 bits, OR1K 1.1 field layout).
module mor1kx_cfgrs_words
    import mor1kx_cfgrs_spr_pkg::*;
#(
    parameter string FEATURE_DATACACHE        = "NONE",
    parameter string FEATURE_INSTRUCTIONCACHE = "NONE",
    parameter string FEATURE_DMMU             = "NONE",
    parameter string FEATURE_IMMU             = "NONE",
    parameter string FEATURE_PIC              = "ENABLED",
    parameter string FEATURE_TIMER            = "ENABLED",
    parameter string FEATURE_DEBUGUNIT        = "NONE",
    parameter string FEATURE_PERFCOUNTERS     = "NONE",
    parameter string FEATURE_MAC              = "NONE",
    parameter string FEATURE_FPU              = "NONE",
    parameter string FEATURE_DELAYSLOT        = "NONE",
    parameter string FEATURE_EVBAR            = "NONE",
    parameter string FEATURE_AECSR            = "NONE",
    parameter int    OPTION_DCACHE_BLOCK_WIDTH = 5,
    parameter int    OPTION_DCACHE_SET_WIDTH   = 9,
    parameter int    OPTION_DCACHE_WAYS        = 2,
    parameter int    OPTION_ICACHE_BLOCK_WIDTH = 5,
    parameter int    OPTION_ICACHE_SET_WIDTH   = 9,
    parameter int    OPTION_ICACHE_WAYS        = 2,
    parameter int    OPTION_DMMU_SET_WIDTH     = 6,
    parameter int    OPTION_DMMU_WAYS          = 1,
    parameter int    OPTION_IMMU_SET_WIDTH     = 6,
    parameter int    OPTION_IMMU_WAYS          = 1,
    parameter int    OPTION_PERFCOUNTERS_NUM   = 0,
    parameter int    OPTION_RF_NUM_SHADOW_GPR  = 0,
    parameter logic [7:0] OPTION_PIPELINE_ID   = 8'h00
) (
    output logic [31:0] vr,
    output logic [31:0] vr2,
    output logic [31:0] avr,
    output logic [31:0] upr,
    output logic [31:0] cpucfgr,
    output logic [31:0] dmmucfgr,
    output logic [31:0] immucfgr,
    output logic [31:0] dccfgr,
    output logic [31:0] iccfgr,
    output logic [31:0] dcfgr,
    output logic [31:0] pccfgr
);

    localparam bit HAS_DC   = (FEATURE_DATACACHE != "NONE");
    localparam bit HAS_IC   = (FEATURE_INSTRUCTIONCACHE != "NONE");
    localparam bit HAS_DMMU = (FEATURE_DMMU != "NONE");
    localparam bit HAS_IMMU = (FEATURE_IMMU != "NONE");
    localparam bit HAS_PIC  = (FEATURE_PIC != "NONE");
    localparam bit HAS_TT   = (FEATURE_TIMER != "NONE");
    localparam bit HAS_DU   = (FEATURE_DEBUGUNIT != "NONE");
    localparam bit HAS_PC   = (FEATURE_PERFCOUNTERS != "NONE");
    localparam bit HAS_MAC  = (FEATURE_MAC != "NONE");
    localparam bit HAS_FPU  = (FEATURE_FPU != "NONE");
    localparam bit HAS_DS   = (FEATURE_DELAYSLOT != "NONE");
    localparam bit HAS_EVB  = (FEATURE_EVBAR != "NONE");
    localparam bit HAS_AE   = (FEATURE_AECSR != "NONE");

    localparam logic [2:0] DC_NCW = cache_ncw(OPTION_DCACHE_WAYS);
    localparam logic [2:0] IC_NCW = cache_ncw(OPTION_ICACHE_WAYS);
    localparam bit DC_CBS = (OPTION_DCACHE_BLOCK_WIDTH == 5);
    localparam bit IC_CBS = (OPTION_ICACHE_BLOCK_WIDTH == 5);

    // NPC holds the counter count minus one
    localparam logic [2:0] PC_NPC =
        3'((OPTION_PERFCOUNTERS_NUM > 0) ? OPTION_PERFCOUNTERS_NUM - 1 : 0);

    // UVRP (bit 6) advertises VR2/AVR
    assign vr  = {OR1K_VR_VERSION, 8'h00, 8'h00, 2'b01, 6'h00};
    assign vr2 = {OR1K_VR2_CPUID, OR1K_VR2_VERSION, 8'h00, OPTION_PIPELINE_ID};
    assign avr = {OR1K_AVR_MAJOR, OR1K_AVR_MINOR, 8'h00, 8'h00};

    assign upr = {8'h00, 13'h0000,
                  HAS_TT, 1'b0, HAS_PIC, HAS_PC, HAS_DU, HAS_MAC,
                  HAS_IMMU, HAS_DMMU, HAS_IC, HAS_DC, 1'b1};

    // ND (bit 10) is set when the core has no delay slot
    assign cpucfgr = {16'h0000,
                      HAS_AE, 1'b0, 1'b0, HAS_EVB, 1'b1, ~HAS_DS,
                      1'b0, 1'b0, HAS_FPU, 1'b0, 1'b1, 1'b0,
                      4'(OPTION_RF_NUM_SHADOW_GPR)};

    assign dmmucfgr = {20'h00000, 4'h0, 3'b000,
                       3'(OPTION_DMMU_SET_WIDTH), 2'(OPTION_DMMU_WAYS - 1)};
    assign immucfgr = {20'h00000, 4'h0, 3'b000,
                       3'(OPTION_IMMU_SET_WIDTH), 2'(OPTION_IMMU_WAYS - 1)};

    assign dccfgr = {17'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                     DC_CBS, 4'(OPTION_DCACHE_SET_WIDTH), DC_NCW};
    assign iccfgr = {17'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                     IC_CBS, 4'(OPTION_ICACHE_SET_WIDTH), IC_NCW};

    assign dcfgr  = '0;
    assign pccfgr = {29'h0000_0000, PC_NPC};

endmodule

// File: rtl/mor1kx_cfgrs_spr.sv
// Group-0 SPR configuration and control register block for mor1kx.
// Serves the read-only identification/config words and the writable EVBAR,
// AECR and AESR state (plus COREID/NUMCORES) over the SPR bus.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   spr_bus_*_i        - SPR bus request (addr, we, stb, write data)
//   spr_bus_dat_o      - read data, valid with ack (0 on error/write)
//   spr_bus_ack_o      - one-cycle acknowledge, one cycle after stb
//   spr_bus_err_o      - access error, qualified by ack
//   core_id_i          - static core index returned by COREID
//   ae_set_i           - per-cause arithmetic-exception event pulses
//   evbar_o            - current exception vector base
//   ae_exception_o     - OR of all AESR bits
module mor1kx_cfgrs_spr
    import mor1kx_cfgrs_spr_pkg::*;
#(
    parameter string FEATURE_DATACACHE        = "NONE",
    parameter string FEATURE_INSTRUCTIONCACHE = "NONE",
    parameter string FEATURE_DMMU             = "NONE",
    parameter string FEATURE_IMMU             = "NONE",
    parameter string FEATURE_PIC              = "ENABLED",
    parameter string FEATURE_TIMER            = "ENABLED",
    parameter string FEATURE_DEBUGUNIT        = "NONE",
    parameter string FEATURE_PERFCOUNTERS     = "NONE",
    parameter string FEATURE_MAC              = "NONE",
    parameter string FEATURE_FPU              = "NONE",
    parameter string FEATURE_DELAYSLOT        = "NONE",
    parameter int    OPTION_DCACHE_BLOCK_WIDTH = 5,
    parameter int    OPTION_DCACHE_SET_WIDTH   = 9,
    parameter int    OPTION_DCACHE_WAYS        = 2,
    parameter int    OPTION_ICACHE_BLOCK_WIDTH = 5,
    parameter int    OPTION_ICACHE_SET_WIDTH   = 9,
    parameter int    OPTION_ICACHE_WAYS        = 2,
    parameter int    OPTION_DMMU_SET_WIDTH     = 6,
    parameter int    OPTION_DMMU_WAYS          = 1,
    parameter int    OPTION_IMMU_SET_WIDTH     = 6,
    parameter int    OPTION_IMMU_WAYS          = 1,
    parameter int    OPTION_PERFCOUNTERS_NUM   = 0,
    parameter int    OPTION_RF_NUM_SHADOW_GPR  = 0,
    parameter string FEATURE_EVBAR            = "NONE",
    parameter string FEATURE_AECSR            = "NONE",
    parameter string FEATURE_MULTICORE        = "NONE",
    parameter int    OPTION_NUM_CORES         = 1,
    parameter logic [31:0] OPTION_RESET_EVBAR = 32'h0000_0000,
    parameter logic [7:0]  OPTION_PIPELINE_ID = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_we_i,
    input  logic        spr_bus_stb_i,
    input  logic [31:0] spr_bus_dat_i,
    output logic [31:0] spr_bus_dat_o,
    output logic        spr_bus_ack_o,
    output logic        spr_bus_err_o,
    input  logic [31:0] core_id_i,
    input  logic [6:0]  ae_set_i,
    output logic [31:0] evbar_o,
    output logic        ae_exception_o
);

    localparam bit HAS_DC   = (FEATURE_DATACACHE != "NONE");
    localparam bit HAS_IC   = (FEATURE_INSTRUCTIONCACHE != "NONE");
    localparam bit HAS_DMMU = (FEATURE_DMMU != "NONE");
    localparam bit HAS_IMMU = (FEATURE_IMMU != "NONE");
    localparam bit HAS_DU   = (FEATURE_DEBUGUNIT != "NONE");
    localparam bit HAS_PC   = (FEATURE_PERFCOUNTERS != "NONE");
    localparam bit HAS_EVB  = (FEATURE_EVBAR != "NONE");
    localparam bit HAS_AE   = (FEATURE_AECSR != "NONE");
    localparam bit HAS_MC   = (FEATURE_MULTICORE != "NONE");

    logic [31:0] w_vr, w_vr2, w_avr, w_upr, w_cpucfgr;
    logic [31:0] w_dmmucfgr, w_immucfgr, w_dccfgr, w_iccfgr, w_dcfgr, w_pccfgr;

    mor1kx_cfgrs_words #(
        .FEATURE_DATACACHE        (FEATURE_DATACACHE),
        .FEATURE_INSTRUCTIONCACHE (FEATURE_INSTRUCTIONCACHE),
        .FEATURE_DMMU             (FEATURE_DMMU),
        .FEATURE_IMMU             (FEATURE_IMMU),
        .FEATURE_PIC              (FEATURE_PIC),
        .FEATURE_TIMER            (FEATURE_TIMER),
        .FEATURE_DEBUGUNIT        (FEATURE_DEBUGUNIT),
        .FEATURE_PERFCOUNTERS     (FEATURE_PERFCOUNTERS),
        .FEATURE_MAC              (FEATURE_MAC),
        .FEATURE_FPU              (FEATURE_FPU),
        .FEATURE_DELAYSLOT        (FEATURE_DELAYSLOT),
        .FEATURE_EVBAR            (FEATURE_EVBAR),
        .FEATURE_AECSR            (FEATURE_AECSR),
        .OPTION_DCACHE_BLOCK_WIDTH(OPTION_DCACHE_BLOCK_WIDTH),
        .OPTION_DCACHE_SET_WIDTH  (OPTION_DCACHE_SET_WIDTH),
        .OPTION_DCACHE_WAYS       (OPTION_DCACHE_WAYS),
        .OPTION_ICACHE_BLOCK_WIDTH(OPTION_ICACHE_BLOCK_WIDTH),
        .OPTION_ICACHE_SET_WIDTH  (OPTION_ICACHE_SET_WIDTH),
        .OPTION_ICACHE_WAYS       (OPTION_ICACHE_WAYS),
        .OPTION_DMMU_SET_WIDTH    (OPTION_DMMU_SET_WIDTH),
        .OPTION_DMMU_WAYS         (OPTION_DMMU_WAYS),
        .OPTION_IMMU_SET_WIDTH    (OPTION_IMMU_SET_WIDTH),
        .OPTION_IMMU_WAYS         (OPTION_IMMU_WAYS),
        .OPTION_PERFCOUNTERS_NUM  (OPTION_PERFCOUNTERS_NUM),
        .OPTION_RF_NUM_SHADOW_GPR (OPTION_RF_NUM_SHADOW_GPR),
        .OPTION_PIPELINE_ID       (OPTION_PIPELINE_ID)
    ) u_words (
        .vr       (w_vr),
        .vr2      (w_vr2),
        .avr      (w_avr),
        .upr      (w_upr),
        .cpucfgr  (w_cpucfgr),
        .dmmucfgr (w_dmmucfgr),
        .immucfgr (w_immucfgr),
        .dccfgr   (w_dccfgr),
        .iccfgr   (w_iccfgr),
        .dcfgr    (w_dcfgr),
        .pccfgr   (w_pccfgr)
    );

    spr_state_t  state;
    logic [31:OR1K_EVBAR_LSB] evbar_q;
    logic [6:0]  aecr_q;
    logic [6:0]  aesr_q;

    logic [10:0] idx;
    logic        access;
    logic        present;
    logic        writable;
    logic        acc_err;
    logic [31:0] rd_dat;
    logic        wr_evbar, wr_aecr, wr_aesr;
    logic [6:0]  aesr_w1c;
    logic [6:0]  aesr_next;

    // Write data bits [12:7] have no destination in any group-0 register
    logic        unused_dat;
    assign unused_dat = ^spr_bus_dat_i[12:7];

    assign idx    = spr_bus_addr_i[10:0];
    assign access = (state == ST_IDLE) && spr_bus_stb_i &&
                    (spr_bus_addr_i[15:11] == 5'd0);

    always_comb begin
        present  = 1'b0;
        writable = 1'b0;
        rd_dat   = '0;
        case (idx)
            OR1K_SPR_VR_IDX:       begin present = 1'b1; rd_dat = w_vr;      end
            OR1K_SPR_UPR_IDX:      begin present = 1'b1; rd_dat = w_upr;     end
            OR1K_SPR_CPUCFGR_IDX:  begin present = 1'b1; rd_dat = w_cpucfgr; end
            OR1K_SPR_DMMUCFGR_IDX: begin present = HAS_DMMU; rd_dat = w_dmmucfgr; end
            OR1K_SPR_IMMUCFGR_IDX: begin present = HAS_IMMU; rd_dat = w_immucfgr; end
            OR1K_SPR_DCCFGR_IDX:   begin present = HAS_DC; rd_dat = w_dccfgr; end
            OR1K_SPR_ICCFGR_IDX:   begin present = HAS_IC; rd_dat = w_iccfgr; end
            OR1K_SPR_DCFGR_IDX:    begin present = HAS_DU; rd_dat = w_dcfgr;  end
            OR1K_SPR_PCCFGR_IDX:   begin present = HAS_PC; rd_dat = w_pccfgr; end
            OR1K_SPR_VR2_IDX:      begin present = 1'b1; rd_dat = w_vr2;     end
            OR1K_SPR_AVR_IDX:      begin present = 1'b1; rd_dat = w_avr;     end
            OR1K_SPR_EVBAR_IDX: begin
                present  = HAS_EVB;
                writable = HAS_EVB;
                rd_dat   = {evbar_q, {OR1K_EVBAR_LSB{1'b0}}};
            end
            OR1K_SPR_AECR_IDX: begin
                present  = HAS_AE;
                writable = HAS_AE;
                rd_dat   = {25'h0, aecr_q};
            end
            OR1K_SPR_AESR_IDX: begin
                present  = HAS_AE;
                writable = HAS_AE;
                rd_dat   = {25'h0, aesr_q};
            end
            OR1K_SPR_COREID_IDX:   begin present = HAS_MC; rd_dat = core_id_i; end
            OR1K_SPR_NUMCORES_IDX: begin present = HAS_MC; rd_dat = 32'(OPTION_NUM_CORES); end
            default: ;
        endcase
    end

    assign acc_err  = !present || (spr_bus_we_i && !writable);
    assign wr_evbar = access && spr_bus_we_i && !acc_err && (idx == OR1K_SPR_EVBAR_IDX);
    assign wr_aecr  = access && spr_bus_we_i && !acc_err && (idx == OR1K_SPR_AECR_IDX);
    assign wr_aesr  = access && spr_bus_we_i && !acc_err && (idx == OR1K_SPR_AESR_IDX);

    // Clear is applied before set so a same-cycle event survives a W1C
    assign aesr_w1c  = wr_aesr ? spr_bus_dat_i[6:0] : '0;
    assign aesr_next = (aesr_q & ~aesr_w1c) | (ae_set_i & aecr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            spr_bus_ack_o  <= 1'b0;
            spr_bus_err_o  <= 1'b0;
            spr_bus_dat_o  <= '0;
            evbar_q        <= OPTION_RESET_EVBAR[31:OR1K_EVBAR_LSB];
            aecr_q         <= '0;
            aesr_q         <= '0;
            ae_exception_o <= 1'b0;
        end else begin
            aesr_q         <= aesr_next;
            ae_exception_o <= |aesr_next;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        state         <= ST_RESP;
                        spr_bus_ack_o <= 1'b1;
                        spr_bus_err_o <= acc_err;
                        spr_bus_dat_o <= (acc_err || spr_bus_we_i) ? '0 : rd_dat;
                        if (wr_evbar)
                            evbar_q <= spr_bus_dat_i[31:OR1K_EVBAR_LSB];
                        if (wr_aecr)
                            aecr_q <= spr_bus_dat_i[6:0];
                    end
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    spr_bus_ack_o <= 1'b0;
                    spr_bus_err_o <= 1'b0;
                    spr_bus_dat_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign evbar_o = {evbar_q, {OR1K_EVBAR_LSB{1'b0}}};

endmodule

// File: tb/tb_mor1kx_cfgrs_spr.sv
// Directed bench for mor1kx_cfgrs_spr. Instance A enables EVBAR, AECSR,
// multicore and both caches; instance B leaves multicore off. Expected bus
// responses are queued when a request is driven and compared on ack.
module tb_mor1kx_cfgrs_spr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] addr;
    logic        we;
    logic        stb_a, stb_b;
    logic [31:0] wdat;
    logic [31:0] core_id;
    logic [6:0]  ae_set;

    logic [31:0] dat_a, dat_b, evbar_a, evbar_b;
    logic        ack_a, ack_b, err_a, err_b, aex_a, aex_b;

    mor1kx_cfgrs_spr #(
        .FEATURE_DATACACHE        ("ENABLED"),
        .FEATURE_INSTRUCTIONCACHE ("ENABLED"),
        .OPTION_ICACHE_WAYS       (64),
        .OPTION_ICACHE_SET_WIDTH  (7),
        .OPTION_ICACHE_BLOCK_WIDTH(4),
        .FEATURE_EVBAR            ("ENABLED"),
        .FEATURE_AECSR            ("ENABLED"),
        .FEATURE_MULTICORE        ("ENABLED"),
        .OPTION_NUM_CORES         (4),
        .OPTION_RESET_EVBAR       (32'h0000_2FFF),
        .OPTION_PIPELINE_ID       (8'h01)
    ) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_bus_addr_i (addr),
        .spr_bus_we_i   (we),
        .spr_bus_stb_i  (stb_a),
        .spr_bus_dat_i  (wdat),
        .spr_bus_dat_o  (dat_a),
        .spr_bus_ack_o  (ack_a),
        .spr_bus_err_o  (err_a),
        .core_id_i      (core_id),
        .ae_set_i       (ae_set),
        .evbar_o        (evbar_a),
        .ae_exception_o (aex_a)
    );

    mor1kx_cfgrs_spr #(
        .FEATURE_MULTICORE ("NONE"),
        .OPTION_NUM_CORES  (4)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_bus_addr_i (addr),
        .spr_bus_we_i   (we),
        .spr_bus_stb_i  (stb_b),
        .spr_bus_dat_i  (wdat),
        .spr_bus_dat_o  (dat_b),
        .spr_bus_ack_o  (ack_b),
        .spr_bus_err_o  (err_b),
        .core_id_i      (core_id),
        .ae_set_i       (ae_set),
        .evbar_o        (evbar_b),
        .ae_exception_o (aex_b)
    );

    typedef struct {
        logic [31:0] dat;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One bus access on instance A (sel=0) or B (sel=1); ae drives ae_set_i
    // for the commit edge only.
    task automatic acc(input bit sel, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [6:0] ae,
                       input logic [31:0] edat, input logic [31:0] emask,
                       input logic eerr, input string tag);
        exp_t e;
        int   n;
        logic ack, err;
        logic [31:0] dat;
        sb.push_back('{dat: edat, mask: emask, err: eerr});
        @(negedge clk);
        addr   = a;
        we     = w;
        wdat   = d;
        ae_set = ae;
        if (sel) stb_b = 1'b1; else stb_a = 1'b1;
        @(posedge clk);
        #1;
        stb_a  = 1'b0;
        stb_b  = 1'b0;
        we     = 1'b0;
        ae_set = '0;
        n = 0;
        while (!(sel ? ack_b : ack_a) && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        ack = sel ? ack_b : ack_a;
        err = sel ? err_b : err_a;
        dat = sel ? dat_b : dat_a;
        e = sb.pop_front();
        check1({tag, " ack"}, ack, 1'b1);
        if (ack) begin
            check({tag, " dat"}, dat & e.mask, e.dat & e.mask);
            check1({tag, " err"}, err, e.err);
        end
        @(posedge clk);
        #1;
        check1({tag, " ack_drop"}, sel ? ack_b : ack_a, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        we      = 1'b0;
        stb_a   = 1'b0;
        stb_b   = 1'b0;
        wdat    = '0;
        core_id = 32'd2;
        ae_set  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst evbar", evbar_a, 32'h0000_2000);
        check1("rst ack", ack_a, 1'b0);
        check1("rst err", err_a, 1'b0);
        check("rst dat", dat_a, 32'h0);
        check1("rst aex", aex_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        acc(0, 0, 16'd13, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, "aesr_rst");
        acc(0, 0, 16'd9,  0, 0, 32'h01, 32'hFF, 0, "vr2_pid");
        acc(0, 1, 16'd0,  32'hFFFF_FFFF, 0, 32'h0, 32'hFFFF_FFFF, 1, "vr_wr");
        acc(0, 0, 16'd0,  0, 0, 32'h40, 32'h40, 0, "vr_rd");
        acc(0, 0, 16'd1,  0, 0, 32'h507, 32'h7FF, 0, "upr");
        acc(0, 0, 16'd2,  0, 0, 32'h9400, 32'h9400, 0, "cpucfgr");
        acc(0, 0, 16'd5,  0, 0, 32'hC9, 32'hFF, 0, "dccfgr");
        acc(0, 0, 16'd6,  0, 0, 32'h3D, 32'hFF, 0, "iccfgr_clamp");
        acc(0, 0, 16'd3,  0, 0, 32'h0, 32'hFFFF_FFFF, 1, "dmmu_none");
        acc(0, 0, 16'd14, 0, 0, 32'h0, 32'hFFFF_FFFF, 1, "unmapped");

        acc(0, 1, 16'd11, 32'hABCD_FFFF, 0, 32'h0, 32'h0, 0, "evbar_wr");
        check("evbar_o", evbar_a, 32'hABCD_E000);
        acc(0, 0, 16'd11, 0, 0, 32'hABCD_E000, 32'hFFFF_FFFF, 0, "evbar_rd");

        acc(0, 1, 16'd12, 32'hFFFF_FF90, 0, 32'h0, 32'h0, 0, "aecr_wr");
        acc(0, 0, 16'd12, 0, 0, 32'h10, 32'hFFFF_FFFF, 0, "aecr_rd");
        check1("aex_idle", aex_a, 1'b0);

        @(negedge clk);
        ae_set = 7'h11;
        @(posedge clk);
        #1;
        ae_set = '0;
        check1("aex_set", aex_a, 1'b1);
        acc(0, 0, 16'd13, 0, 0, 32'h10, 32'hFFFF_FFFF, 0, "aesr_set");

        acc(0, 1, 16'd13, 32'h10, 7'h10, 32'h0, 32'h0, 0, "aesr_w1c_race");
        acc(0, 0, 16'd13, 0, 0, 32'h10, 32'hFFFF_FFFF, 0, "aesr_kept");
        check1("aex_kept", aex_a, 1'b1);
        acc(0, 1, 16'd13, 32'h10, 0, 32'h0, 32'h0, 0, "aesr_w1c");
        acc(0, 0, 16'd13, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, "aesr_clr");
        check1("aex_clr", aex_a, 1'b0);

        // Foreign group: write to what would be EVBAR in group 1
        @(negedge clk);
        addr  = 16'h080B;
        we    = 1'b1;
        wdat  = 32'h5555_0000;
        stb_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("grp1 ack", ack_a, 1'b0);
        end
        stb_a = 1'b0;
        we    = 1'b0;
        check("grp1 evbar", evbar_a, 32'hABCD_E000);

        acc(0, 0, 16'd128, 0, 0, 32'd2, 32'hFFFF_FFFF, 0, "coreid");
        acc(0, 0, 16'd129, 0, 0, 32'd4, 32'hFFFF_FFFF, 0, "numcores");
        acc(1, 0, 16'd128, 0, 0, 32'h0, 32'hFFFF_FFFF, 1, "coreid_none");

        // Reset held across the commit edge: nothing is written
        @(negedge clk);
        addr  = 16'd11;
        we    = 1'b1;
        wdat  = 32'h1234_0000;
        stb_a = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        stb_a = 1'b0;
        we    = 1'b0;
        check1("rst_mid ack", ack_a, 1'b0);
        check("rst_mid evbar", evbar_a, 32'h0000_2000);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the ack cycle clears ack asynchronously
        @(negedge clk);
        addr  = 16'd11;
        we    = 1'b1;
        wdat  = 32'h5555_0000;
        stb_a = 1'b1;
        @(posedge clk);
        #1;
        stb_a = 1'b0;
        we    = 1'b0;
        check1("ack_pre_rst", ack_a, 1'b1);
        check("evbar_pre_rst", evbar_a, 32'h5555_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check1("ack_async_rst", ack_a, 1'b0);
        check("evbar_async_rst", evbar_a, 32'h0000_2000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
